// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: requester count,
// FSM state encoding and the hold-counter width.
package arb_pkg;

    localparam int N_REQ  = 4;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [1:0] i);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_prio_sel.sv
// Rotating priority selector: first set request bit scanning upward from ptr,
// wrapping modulo 4.
module rr_prio_sel
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    output logic [1:0]       idx,
    output logic             any
);

    logic [1:0] cand;

    always_comb begin
        idx  = ptr;
        any  = 1'b0;
        cand = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr + 2'(k);
            if (!any && req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a bounded grant tenure; all outputs
// are registered and a grant is always separated from the next by an IDLE cycle.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [1:0]       gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state, state_nxt;
    logic [1:0]        ptr, ptr_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [N_REQ-1:0]  gnt_nxt;
    logic [1:0]        gnt_id_nxt;
    logic              gnt_valid_nxt;
    logic              timeout_nxt;

    logic [1:0]        sel_idx;
    logic              sel_any;
    logic              rel_done, rel_drop, rel_limit;

    rr_prio_sel u_sel (
        .req (req),
        .ptr (ptr),
        .idx (sel_idx),
        .any (sel_any)
    );

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        hold_cnt_nxt  = hold_cnt;
        gnt_nxt       = gnt;
        gnt_id_nxt    = gnt_id;
        gnt_valid_nxt = gnt_valid;
        timeout_nxt   = 1'b0;
        rel_done      = done;
        rel_drop      = !req[gnt_id];
        rel_limit     = (hold_cnt == HOLD_LAST);

        case (state)
            IDLE: begin
                // done is meaningless without an owner, so IDLE ignores it
                if (sel_any) begin
                    state_nxt     = BUSY;
                    gnt_nxt       = onehot(sel_idx);
                    gnt_id_nxt    = sel_idx;
                    gnt_valid_nxt = 1'b1;
                    ptr_nxt       = sel_idx + 2'd1;
                    hold_cnt_nxt  = '0;
                end else begin
                    gnt_nxt       = '0;
                    gnt_valid_nxt = 1'b0;
                end
            end
            BUSY: begin
                if (rel_done || rel_drop || rel_limit) begin
                    state_nxt     = IDLE;
                    gnt_nxt       = '0;
                    gnt_valid_nxt = 1'b0;
                    // a revocation only counts as timeout when nothing else ended the tenure
                    timeout_nxt   = rel_limit && !rel_done && !rel_drop;
                end else begin
                    hold_cnt_nxt  = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt     = IDLE;
                gnt_nxt       = '0;
                gnt_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_cnt_nxt;
            gnt       <= gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            gnt_valid <= gnt_valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: directed scenarios plus randomized
// req/done/reset traffic against an owner/pointer reference model.
module tb_rr_arbiter_4;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int m_owner = -1;
    int m_ptr   = 0;
    int m_ten   = 0;
    bit m_to    = 1'b0;
    logic [3:0] sel_req = 4'b0;
    bit prev_vld = 1'b0;
    int starve[4] = '{0, 0, 0, 0};

    rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        sel_req = req;
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_ten   = 0;
            m_to    = 1'b0;
            for (int i = 0; i < 4; i++) starve[i] = 0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (m_owner < 0 && req[c]) begin
                    m_owner = c;
                    m_ptr   = (c + 1) % 4;
                    m_ten   = 0;
                end
            end
        end else begin
            if (done || !req[m_owner] || m_ten == MAX_HOLD - 1) begin
                m_to    = (m_ten == MAX_HOLD - 1) && !done && req[m_owner];
                m_owner = -1;
            end else begin
                m_ten++;
                m_to = 1'b0;
            end
        end
    endtask

    task automatic compare();
        logic [3:0] eg;
        int worst;
        eg = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
        check_eq("gnt", gnt, eg);
        check_eq("gnt_valid", gnt_valid, (m_owner >= 0));
        check_eq("timeout", timeout, m_to);
        if (m_owner >= 0) check_eq("gnt_id", gnt_id, m_owner);
        check_eq("onehot", ($countones(gnt) <= 1), 1);
        // fairness: count arbitrations a requester waited through while asserting
        if (gnt_valid && !prev_vld && rst_n) begin
            worst = 0;
            for (int i = 0; i < 4; i++) begin
                if (i == int'(gnt_id)) starve[i] = 0;
                else if (sel_req[i])   starve[i]++;
                else                   starve[i] = 0;
                if (starve[i] > worst) worst = starve[i];
            end
            check_eq("starve", (worst < 4), 1);
        end
        prev_vld = gnt_valid;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0;
        done  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0;
        done  = 1'b0;

        // reset state
        do_reset();
        check_eq("rst_gnt", gnt, 4'b0);
        check_eq("rst_id", gnt_id, 2'd0);
        check_eq("rst_vld", gnt_valid, 1'b0);
        check_eq("rst_to", timeout, 1'b0);

        // full request set rotates 0,1,2,3,0
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("seq_id", gnt_id, k % 4);
            check_eq("seq_vld", gnt_valid, 1'b1);
            done = 1'b1;
            step();
            done = 1'b0;
            check_eq("seq_idle", gnt, 4'b0);
        end

        // pointer past owner 1 picks 0 before 1, then pointer sits at 1
        do_reset();
        req = 4'b0010;
        step();
        check_eq("p2_first", gnt, 4'b0010);
        req  = 4'b0011;
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        check_eq("p2_win0", gnt, 4'b0001);
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        check_eq("p1_win1", gnt, 4'b0010);

        // tenure limit: 4 cycles of grant, then a timeout pulse
        do_reset();
        req = 4'b0100;
        for (int k = 0; k < MAX_HOLD; k++) begin
            step();
            check_eq("hold_gnt", gnt, 4'b0100);
            check_eq("hold_to", timeout, 1'b0);
        end
        step();
        check_eq("lim_gnt", gnt, 4'b0);
        check_eq("lim_to", timeout, 1'b1);
        step();
        check_eq("lim_to_clr", timeout, 1'b0);
        check_eq("lim_regrant", gnt, 4'b0100);

        // done coinciding with the limit is a normal release
        do_reset();
        req = 4'b0001;
        for (int k = 0; k < MAX_HOLD; k++) step();
        done = 1'b1;
        step();
        done = 1'b0;
        check_eq("coinc_to", timeout, 1'b0);
        check_eq("coinc_gnt", gnt, 4'b0);

        // owner drops its request
        do_reset();
        req = 4'b1010;
        step();
        check_eq("drop_own", gnt, 4'b0010);
        req = 4'b1000;
        step();
        check_eq("drop_clr", gnt, 4'b0);
        check_eq("drop_to", timeout, 1'b0);
        step();
        check_eq("drop_next", gnt, 4'b1000);

        // reset in the middle of a tenure
        do_reset();
        req = 4'b0010;
        step();
        check_eq("mid_own", gnt, 4'b0010);
        rst_n = 1'b0;
        step();
        check_eq("mid_gnt", gnt, 4'b0);
        check_eq("mid_vld", gnt_valid, 1'b0);
        check_eq("mid_id", gnt_id, 2'd0);
        check_eq("mid_to", timeout, 1'b0);
        rst_n = 1'b1;
        req   = 4'b1010;
        step();
        check_eq("mid_after", gnt, 4'b0010);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            done  = ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 499) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
